// File: rtl/pmp_pkg.sv
// pmp_pkg: shared PMP A-modes, cfg-byte layout, CSR bases, error codes and encoder states
package pmp_pkg;
    typedef enum logic [1:0] {
        A_OFF   = 2'd0,
        A_TOR   = 2'd1,
        A_NA4   = 2'd2,
        A_NAPOT = 2'd3
    } a_mode_e;
    typedef enum logic [1:0] {
        ERR_OK     = 2'd0,
        ERR_LOCKED = 2'd1,
        ERR_ALIGN  = 2'd2,
        ERR_RANGE  = 2'd3
    } err_e;
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLASSIFY,
        S_WR_LO,
        S_WR_ADDR,
        S_WR_CFG,
        S_RESP
    } state_e;
    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        a_mode_e    a;
        logic [2:0] xwr;
    } cfg_byte_t;
    localparam logic [11:0] CSR_PMPCFG_BASE  = 12'h3A0;
    localparam logic [11:0] CSR_PMPADDR_BASE = 12'h3B0;
    function automatic logic [7:0] pack_cfg(input logic l, input a_mode_e a, input logic [2:0] xwr);
        cfg_byte_t c;
        c = '{l: l, rsvd: 2'b00, a: a, xwr: xwr};
        return c;
    endfunction
endpackage

// File: rtl/pmp_mode_classify.sv
// pmp_mode_classify: picks the A-mode, error code and pmpaddr encodings for a region descriptor
module pmp_mode_classify
    import pmp_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic [IDX_W-1:0]       idx,
    input  logic [31:0]            base,
    input  logic [31:0]            len,
    input  logic [NUM_ENTRIES-1:0] locks,
    output a_mode_e                mode,
    output err_e                   err,
    output logic                   need_lo,
    output logic [31:0]            addr_lo,
    output logic [31:0]            addr_hi
);
    logic [32:0] sum;
    logic pow2, napot, tor, overflow, misaligned, bad_tor0, locked;
    always_comb begin
        sum        = {1'b0, base} + {1'b0, len};
        pow2       = (len != 32'd0) && ((len & (len - 32'd1)) == 32'd0);
        napot      = pow2 && (len >= 32'd8) && ((base & (len - 32'd1)) == 32'd0);
        mode       = (len == 32'd4) ? A_NA4 : napot ? A_NAPOT : A_TOR;
        tor        = mode == A_TOR;
        overflow   = sum[32] && (sum[31:0] != 32'd0);
        misaligned = (len == 32'd0) || (len[1:0] != 2'd0) || (base[1:0] != 2'd0);
        bad_tor0   = tor && (idx == '0) && (base != 32'd0);
        locked     = locks[idx] || (tor && (idx != '0) && locks[idx - IDX_W'(1)]);
        err        = misaligned ? ERR_ALIGN : (overflow || bad_tor0) ? ERR_RANGE : locked ? ERR_LOCKED : ERR_OK;
        need_lo    = tor && (idx != '0);
        addr_lo    = base >> 2;
        addr_hi    = (mode == A_NAPOT) ? ((base >> 2) | ((len >> 3) - 32'd1)) : tor ? {1'b0, sum[32:2]} : (base >> 2);
    end
endmodule

// File: rtl/pmp_region_encoder.sv
// pmp_region_encoder: turns region descriptors into sequenced pmpaddr/pmpcfg CSR writes with a lock-aware cfg shadow
module pmp_region_encoder
    import pmp_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_idx,
    input  logic [31:0]      req_base,
    input  logic [31:0]      req_len,
    input  logic [2:0]       req_perm,
    input  logic             req_lock,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic [11:0]      wr_addr,
    output logic [31:0]      wr_data,
    output logic             rsp_valid,
    output logic [1:0]       rsp_err,
    output logic [1:0]       rsp_mode
);
    state_e state;
    logic [IDX_W-1:0] idx;
    logic [31:0] base, len;
    logic [2:0] perm;
    logic lock;
    logic [7:0] shadow [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] locks;
    a_mode_e mode;
    err_e err;
    logic need_lo, hs;
    logic [31:0] addr_lo, addr_hi, cfg_word;
    logic [7:0] cfg_byte;

    pmp_mode_classify #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W)) u_classify (
        .idx     (idx),
        .base    (base),
        .len     (len),
        .locks   (locks),
        .mode    (mode),
        .err     (err),
        .need_lo (need_lo),
        .addr_lo (addr_lo),
        .addr_hi (addr_hi)
    );

    assign req_ready = state == S_IDLE;
    assign hs        = wr_valid && wr_ready;

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) locks[i] = shadow[i][7];
        cfg_byte = pack_cfg(lock, mode, perm);
        for (int i = 0; i < 4; i++)
            cfg_word[8*i +: 8] = (2'(i) == idx[1:0]) ? cfg_byte : shadow[{idx[IDX_W-1:2], 2'(i)}];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= '0;
            rsp_mode  <= '0;
            idx       <= '0;
            base      <= '0;
            len       <= '0;
            perm      <= '0;
            lock      <= 1'b0;
            for (int i = 0; i < NUM_ENTRIES; i++) shadow[i] <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: if (req_valid) begin
                    idx   <= req_idx;
                    base  <= req_base;
                    len   <= req_len;
                    perm  <= req_perm;
                    lock  <= req_lock;
                    state <= S_CLASSIFY;
                end
                S_CLASSIFY: if (err != ERR_OK) begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= err;
                    rsp_mode  <= A_OFF;
                end else begin
                    state    <= need_lo ? S_WR_LO : S_WR_ADDR;
                    wr_valid <= 1'b1;
                    wr_addr  <= CSR_PMPADDR_BASE + 12'(need_lo ? idx - IDX_W'(1) : idx);
                    wr_data  <= need_lo ? addr_lo : addr_hi;
                end
                S_WR_LO: if (hs) begin
                    state   <= S_WR_ADDR;
                    wr_addr <= CSR_PMPADDR_BASE + 12'(idx);
                    wr_data <= addr_hi;
                end
                S_WR_ADDR: if (hs) begin
                    state   <= S_WR_CFG;
                    wr_addr <= CSR_PMPCFG_BASE + 12'(idx >> 2);
                    wr_data <= cfg_word;
                end
                S_WR_CFG: if (hs) begin
                    state       <= S_RESP;
                    wr_valid    <= 1'b0;
                    shadow[idx] <= cfg_byte;
                    rsp_valid   <= 1'b1;
                    rsp_err     <= ERR_OK;
                    rsp_mode    <= mode;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pmp_region_encoder.sv
// tb_pmp_region_encoder: scoreboard bench for the PMP region encoder
module tb_pmp_region_encoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_idx = '0;
    logic [31:0] req_base = '0;
    logic [31:0] req_len = '0;
    logic [2:0]  req_perm = '0;
    logic        req_lock = 1'b0;
    logic        wr_valid;
    logic        wr_ready = 1'b1;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic        rsp_valid;
    logic [1:0]  rsp_err;
    logic [1:0]  rsp_mode;

    pmp_region_encoder #(.NUM_ENTRIES(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_idx   (req_idx),
        .req_base  (req_base),
        .req_len   (req_len),
        .req_perm  (req_perm),
        .req_lock  (req_lock),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_mode  (rsp_mode)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;
    typedef struct {
        logic [1:0] err;
        logic [1:0] mode;
        int         at;
    } rsp_t;
    wr_t  exp_wr[$];
    rsp_t exp_rsp[$];

    function automatic wr_t mk_wr(input logic [11:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        return w;
    endfunction

    initial begin
        logic        prev_wv, prev_hs;
        logic [11:0] prev_addr;
        logic [31:0] prev_data;
        wr_t  ew;
        rsp_t er;
        prev_wv = 1'b0;
        prev_hs = 1'b0;
        prev_addr = '0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_wv = 1'b0;
            end else begin
                if (prev_wv && !prev_hs) begin
                    tests++;
                    if (wr_valid !== 1'b1 || wr_addr !== prev_addr || wr_data !== prev_data) begin
                        fails++;
                        $display("FAIL wr_hold: got v=%b %h/%h, want v=1 %h/%h", wr_valid, wr_addr, wr_data, prev_addr, prev_data);
                    end
                end
                if (wr_valid === 1'b1 && wr_ready === 1'b1) begin
                    tests++;
                    if (exp_wr.size() == 0) begin
                        fails++;
                        $display("FAIL wr_unexpected: got %h=%h at cycle %0d, want no write", wr_addr, wr_data, cyc);
                    end else begin
                        ew = exp_wr.pop_front();
                        if (wr_addr !== ew.addr || wr_data !== ew.data) begin
                            fails++;
                            $display("FAIL wr_data: got %h=%h, want %h=%h", wr_addr, wr_data, ew.addr, ew.data);
                        end
                    end
                end
                if (rsp_valid === 1'b1) begin
                    tests++;
                    if (exp_rsp.size() == 0) begin
                        fails++;
                        $display("FAIL rsp_unexpected: got err=%0d mode=%0d at cycle %0d, want none", rsp_err, rsp_mode, cyc);
                    end else begin
                        er = exp_rsp.pop_front();
                        if (rsp_err !== er.err || rsp_mode !== er.mode || cyc != er.at) begin
                            fails++;
                            $display("FAIL rsp: got err=%0d mode=%0d cycle %0d, want err=%0d mode=%0d cycle %0d",
                                     rsp_err, rsp_mode, cyc, er.err, er.mode, er.at);
                        end
                    end
                end
                prev_wv   = wr_valid;
                prev_hs   = wr_valid && wr_ready;
                prev_addr = wr_addr;
                prev_data = wr_data;
            end
        end
    end

    task automatic send(input logic [3:0] idx, input logic [31:0] base, input logic [31:0] len,
                        input logic [2:0] perm, input logic lock,
                        input logic [1:0] err, input logic [1:0] mode, input int lat, output int t0);
        rsp_t r;
        int n;
        n = 0;
        @(posedge clk); #1;
        while (req_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (req_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL req_ready_timeout: got %b after %0d cycles, want 1", req_ready, n);
        end
        t0 = cyc;
        if (lat > 0) begin
            r.err  = err;
            r.mode = mode;
            r.at   = t0 + lat;
            exp_rsp.push_back(r);
        end
        req_valid = 1'b1;
        req_idx   = idx;
        req_base  = base;
        req_len   = len;
        req_perm  = perm;
        req_lock  = lock;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_rsp.size() != 0 || exp_wr.size() != 0) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (exp_rsp.size() != 0 || exp_wr.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d writes %0d rsps outstanding, want 0 0", exp_wr.size(), exp_rsp.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (req_ready !== 1'b1 || wr_valid !== 1'b0 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got ready=%b wv=%b rv=%b, want 1 0 0", req_ready, wr_valid, rsp_valid);
        end
        tests++;
        if (wr_addr !== 12'h0 || wr_data !== 32'h0 || rsp_err !== 2'd0 || rsp_mode !== 2'd0) begin
            fails++;
            $display("FAIL reset_data: got addr=%h data=%h err=%0d mode=%0d, want all 0", wr_addr, wr_data, rsp_err, rsp_mode);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_napot();
        int t0;
        exp_wr.push_back(mk_wr(12'h3B3, 32'h2000_01FF));
        exp_wr.push_back(mk_wr(12'h3A0, 32'h1F00_0000));
        send(4'd3, 32'h8000_0000, 32'h1000, 3'b111, 1'b0, 2'd0, 2'd3, 4, t0);
        wait_done();
    endtask

    task automatic test_na4();
        int t0;
        exp_wr.push_back(mk_wr(12'h3B0, 32'h0000_0400));
        exp_wr.push_back(mk_wr(12'h3A0, 32'h1F00_0011));
        send(4'd0, 32'h1000, 32'd4, 3'b001, 1'b0, 2'd0, 2'd2, 4, t0);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
            fails++;
            $display("FAIL na4_resp_cycle: got ready=%b rv=%b at T+4, want 0 1", req_ready, rsp_valid);
        end
        @(posedge clk); #1;
        tests++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL na4_idle_cycle: got ready=%b rv=%b at T+5, want 1 0", req_ready, rsp_valid);
        end
        wait_done();
    endtask

    task automatic test_tor();
        int t0;
        exp_wr.push_back(mk_wr(12'h3B4, 32'h0000_0040));
        exp_wr.push_back(mk_wr(12'h3B5, 32'h0000_0100));
        exp_wr.push_back(mk_wr(12'h3A1, 32'h0000_0B00));
        send(4'd5, 32'h100, 32'h300, 3'b011, 1'b0, 2'd0, 2'd1, 5, t0);
        wait_done();
    endtask

    task automatic test_tor_idx0();
        int t0;
        exp_wr.push_back(mk_wr(12'h3B0, 32'h0000_00C0));
        exp_wr.push_back(mk_wr(12'h3A0, 32'h1F00_000B));
        send(4'd0, 32'h0, 32'h300, 3'b011, 1'b0, 2'd0, 2'd1, 4, t0);
        wait_done();
    endtask

    task automatic test_lock();
        int t0;
        exp_wr.push_back(mk_wr(12'h3B2, 32'h0000_0800));
        exp_wr.push_back(mk_wr(12'h3A0, 32'h1F91_000B));
        send(4'd2, 32'h2000, 32'd4, 3'b001, 1'b1, 2'd0, 2'd2, 4, t0);
        wait_done();
        send(4'd2, 32'h3000, 32'd4, 3'b011, 1'b0, 2'd1, 2'd0, 2, t0);
        wait_done();
        send(4'd3, 32'h100, 32'h300, 3'b011, 1'b0, 2'd1, 2'd0, 2, t0);
        wait_done();
    endtask

    task automatic test_backpressure();
        int t0;
        exp_wr.push_back(mk_wr(12'h3B6, 32'h0000_101F));
        exp_wr.push_back(mk_wr(12'h3A1, 32'h001D_0B00));
        wr_ready = 1'b0;
        send(4'd6, 32'h4000, 32'h100, 3'b101, 1'b0, 2'd0, 2'd3, 7, t0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            tests++;
            if (wr_valid !== 1'b1 || wr_addr !== 12'h3B6 || wr_data !== 32'h0000_101F || rsp_valid !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold%0d: got v=%b %h=%h rv=%b, want v=1 3b6=0000101f rv=0", k, wr_valid, wr_addr, wr_data, rsp_valid);
            end
        end
        @(posedge clk); #1;
        wr_ready = 1'b1;
        wait_done();
    endtask

    task automatic test_errors();
        int t0;
        send(4'd2, 32'h100, 32'd6, 3'b001, 1'b0, 2'd2, 2'd0, 2, t0);
        wait_done();
        send(4'd7, 32'h102, 32'd4, 3'b001, 1'b0, 2'd2, 2'd0, 2, t0);
        wait_done();
        send(4'd8, 32'hFFFF_FFF0, 32'h20, 3'b001, 1'b0, 2'd3, 2'd0, 2, t0);
        wait_done();
        send(4'd0, 32'h100, 32'h300, 3'b001, 1'b0, 2'd3, 2'd0, 2, t0);
        wait_done();
        exp_wr.push_back(mk_wr(12'h3B8, 32'h3FFF_FFFB));
        exp_wr.push_back(mk_wr(12'h3A2, 32'h0000_0019));
        send(4'd8, 32'hFFFF_FFE0, 32'h20, 3'b001, 1'b0, 2'd0, 2'd3, 4, t0);
        wait_done();
    endtask

    task automatic test_reset_mid();
        int t0;
        wr_ready = 1'b0;
        send(4'd1, 32'h0, 32'd8, 3'b001, 1'b0, 2'd0, 2'd0, 0, t0);
        @(posedge clk); #1;
        tests++;
        if (wr_valid !== 1'b1 || wr_addr !== 12'h3B1) begin
            fails++;
            $display("FAIL rst_mid_pre: got v=%b addr=%h, want 1 3b1", wr_valid, wr_addr);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (wr_valid !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_post: got wv=%b rv=%b ready=%b, want 0 0 1", wr_valid, rsp_valid, req_ready);
        end
        rst_n = 1'b1;
        wr_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        exp_wr.push_back(mk_wr(12'h3B1, 32'h0000_0004));
        exp_wr.push_back(mk_wr(12'h3A0, 32'h0000_1100));
        send(4'd1, 32'h10, 32'd4, 3'b001, 1'b0, 2'd0, 2'd2, 4, t0);
        wait_done();
    endtask

    task automatic test_back_to_back();
        int ta, tb;
        exp_wr.push_back(mk_wr(12'h3B9, 32'h0000_0009));
        exp_wr.push_back(mk_wr(12'h3A2, 32'h0000_1200));
        exp_wr.push_back(mk_wr(12'h3BA, 32'h0000_000A));
        exp_wr.push_back(mk_wr(12'h3A2, 32'h0014_1200));
        send(4'd9, 32'h24, 32'd4, 3'b010, 1'b0, 2'd0, 2'd2, 4, ta);
        send(4'd10, 32'h28, 32'd4, 3'b100, 1'b0, 2'd0, 2'd2, 4, tb);
        tests++;
        if (tb - ta != 5) begin
            fails++;
            $display("FAIL b2b_accept: got gap %0d cycles, want 5", tb - ta);
        end
        wait_done();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by time limit, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_napot();
        test_na4();
        test_tor();
        test_tor_idx0();
        test_lock();
        test_backpressure();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pmp_region_encoder.md
# pmp_region_encoder

Programming-side counterpart of the PMP address matchers. Accepts a region descriptor (entry index, base, byte length, permissions, lock), chooses the A-mode (NA4, NAPOT, else TOR), encodes `pmpaddr`/`pmpcfg` values and issues them as sequenced CSR writes over a valid/ready port. Keeps a shadow of all cfg bytes so packed `pmpcfg` words are rewritten without clobbering neighbouring entries, and enforces lock bits.

## Interface
- `NUM_ENTRIES`, 16, number of PMP entries; multiple of 4, range 4..64.
- `IDX_W`, `$clog2(NUM_ENTRIES)`, entry index width (derived).

- `clk`  in  1  clock; one clock domain.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  descriptor valid.
- `req_ready`  out  1  high only in IDLE.
- `req_idx`  in  IDX_W  target entry n.
- `req_base`  in  32  region base byte address.
- `req_len`  in  32  region length in bytes.
- `req_perm`  in  3  {X,W,R}.
- `req_lock`  in  1  set L bit.
- `wr_valid`  out  1  CSR write valid.
- `wr_ready`  in  1  CSR write accepted.
- `wr_addr`  out  12  CSR address.
- `wr_data`  out  32  CSR data.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_err`  out  2  0 ok, 1 locked, 2 misaligned/zero length, 3 overflow/illegal TOR.
- `rsp_mode`  out  2  A-mode written (0 on error).

## Operation
- Mode: `len==4` → NA4 (2); `len` power of two ≥8 and `base % len == 0` → NAPOT (3); else TOR (1).
- Error check priority: err 2 if `len==0`, `len[1:0]!=0` or `base[1:0]!=0`; else err 3 if `base+len > 2^32` (33-bit sum) or (TOR, `idx==0`, `base!=0`); else err 1 if shadow L of entry idx set, or TOR and `idx>0` and L of idx-1 set.
- Encodings: NA4 `base>>2`; NAPOT `(base>>2) | ((len>>3)-1)`; TOR lo `base>>2` to entry idx-1, hi `(base+len)>>2` to entry idx.
- Cfg byte `{L,2'b00,A[1:0],X,W,R}`; written at `pmpcfg[idx/4]` (CSR 0x3A0+idx/4), byte lane idx%4, other lanes from shadow.
- `pmpaddr[n]` CSR = 0x3B0+n.
- FSM: IDLE → (req_valid) CLASSIFY → error ? RESP : (TOR && idx>0 ? WR_LO : WR_ADDR); WR_LO → WR_ADDR → WR_CFG → RESP → IDLE. Each WR state advances on `wr_valid && wr_ready`. TOR with idx==0, base==0 skips WR_LO.
- Shadow byte for idx updated on WR_CFG handshake only. Locked entries stay locked until reset.

## Timing
- Reset: state IDLE, `req_ready`=1, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_mode`=0, all shadow bytes 0.
- Request captured on cycle T of `req_valid && req_ready`; CLASSIFY T+1; first `wr_valid` T+2.
- With `wr_ready`=1: NA4/NAPOT writes T+2,T+3, `rsp_valid` T+4; TOR writes T+2..T+4, rsp T+5; error rsp T+2, no writes.
- `wr_valid`, `wr_addr`, `wr_data` held stable until handshake; `wr_valid` never deasserts without handshake.
- `rsp_valid` one cycle, no backpressure; `rsp_err`/`rsp_mode` valid only with it. Next request accepted earliest cycle after RESP.
- `rst_n` low mid-sequence: IDLE next edge, in-flight write abandoned, no rsp, shadow cleared.

## Structure
- `pmp_pkg`: A-mode enum (OFF/TOR/NA4/NAPOT), cfg-byte packed struct, CSR base constants 0x3A0/0x3B0, error-code enum, FSM state enum. Shared with the matchers.
- Sub-module `pmp_mode_classify`: combinational mode choice, error code, address encodings.

## Test plan
- NAPOT: idx 3, base 0x8000_0000, len 0x1000, RWX → writes 0x3B3=0x2000_01FF, 0x3A0=0x1F00_0000; rsp err 0 mode 3 at T+4.
- NA4: idx 0, base 0x1000, len 4, R → 0x3B0=0x0000_0400, 0x3A0=0x0000_0011 (preserving byte3 0x1F after test 1 → 0x1F00_0011); mode 2.
- TOR: idx 5, base 0x100, len 0x300, RW → 0x3B4=0x40, 0x3B5=0x100, 0x3A1=0x0000_0B00; mode 1 at T+5.
- Lock: idx 2 NA4 lock=1 (cfg byte 0x91), then idx 2 again → err 1; TOR idx 3 → err 1; no `wr_valid` either time.
- Backpressure: `wr_ready` low 3 cycles on first NAPOT write → outputs stable, rsp at T+7.
- Errors/reset: len 6 → err 2; base 0xFFFF_FFF0 len 0x20 → err 3; `rst_n` low during WR_ADDR → `wr_valid`=0 next cycle, shadow reads 0 on next cfg write.
